// File: rtl/writeback_pc.sv
// writeback_pc: final stage of the sequential Y86-64 datapath.
// Holds the 15-entry register file, the PC and the processor status.
// Commits valE/valM, selects the next PC, latches halt/fault status and
// serves combinational register reads back to decode.
// Optional feature: define WB_INSTRET_EN to build the retired-instruction
// counter; otherwise instret is tied to zero.
// The status register stat is the only control state and is exported
// directly as an output.
module writeback_pc #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter logic [63:0] RSP_INIT = 64'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  icode,
    input  logic [3:0]  rA,
    input  logic [3:0]  rB,
    input  logic        cnd,
    input  logic [63:0] valC,
    input  logic [63:0] valP,
    input  logic [63:0] valE,
    input  logic [63:0] valM,
    input  logic        instr_valid,
    input  logic        imem_error,
    input  logic        dmem_error,
    output logic [63:0] valA,
    output logic [63:0] valB,
    output logic [63:0] pc,
    output logic [2:0]  stat,
    output logic [63:0] instret
);

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    localparam logic [3:0] R_NONE = 4'hF;
    localparam logic [3:0] R_RSP  = 4'h4;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    logic [63:0] regs_q [0:14];
    logic [63:0] pc_q, pc_d;
    logic [2:0]  stat_q, stat_d;
    logic        commit;
    logic [3:0]  src_a, src_b, dst_e, dst_m;

    // Register port selection from the instruction code.
    always_comb begin
        src_a = R_NONE;
        src_b = R_NONE;
        dst_e = R_NONE;
        dst_m = R_NONE;
        case (icode)
            I_RRMOVQ: begin
                src_a = rA;
                if (cnd) dst_e = rB;
            end
            I_IRMOVQ: dst_e = rB;
            I_RMMOVQ: begin
                src_a = rA;
                src_b = rB;
            end
            I_MRMOVQ: begin
                src_b = rB;
                dst_m = rA;
            end
            I_OPQ: begin
                src_a = rA;
                src_b = rB;
                dst_e = rB;
            end
            I_CALL: begin
                src_b = R_RSP;
                dst_e = R_RSP;
            end
            I_RET: begin
                src_a = R_RSP;
                src_b = R_RSP;
                dst_e = R_RSP;
            end
            I_PUSHQ: begin
                src_a = rA;
                src_b = R_RSP;
                dst_e = R_RSP;
            end
            I_POPQ: begin
                src_a = R_RSP;
                src_b = R_RSP;
                dst_e = R_RSP;
                dst_m = rA;
            end
            default: ;
        endcase
    end

    // Combinational reads of pre-edge register contents; "none" reads 0.
    assign valA = (src_a == R_NONE) ? 64'h0 : regs_q[src_a];
    assign valB = (src_b == R_NONE) ? 64'h0 : regs_q[src_b];

    // Fault priority and next-PC selection; nothing moves once stat leaves AOK.
    always_comb begin
        commit = 1'b0;
        stat_d = stat_q;
        pc_d   = pc_q;
        if (stat_q == STAT_AOK) begin
            if (imem_error || dmem_error) begin
                stat_d = STAT_ADR;
            end else if (!instr_valid) begin
                stat_d = STAT_INS;
            end else if (icode == I_HALT) begin
                stat_d = STAT_HLT;
            end else begin
                commit = 1'b1;
                case (icode)
                    I_CALL:  pc_d = valC;
                    I_JXX:   pc_d = cnd ? valC : valP;
                    I_RET:   pc_d = valM;
                    default: pc_d = valP;
                endcase
            end
        end
    end

    // PC and status registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q   <= RESET_PC;
            stat_q <= STAT_AOK;
        end else begin
            pc_q   <= pc_d;
            stat_q <= stat_d;
        end
    end

    // Register file write; the valM write comes last so popq %rsp keeps valM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 15; i++) begin
                regs_q[i] <= (i == 4) ? RSP_INIT : 64'h0;
            end
        end else if (commit) begin
            if (dst_e != R_NONE) regs_q[dst_e] <= valE;
            if (dst_m != R_NONE) regs_q[dst_m] <= valM;
        end
    end

    assign pc   = pc_q;
    assign stat = stat_q;

`ifdef WB_INSTRET_EN
    logic [63:0] instret_q, instret_d;

    // Retired-instruction counter; wraps naturally at 2^64.
    always_comb begin
        instret_d = commit ? instret_q + 64'd1 : instret_q;
    end

    // Counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) instret_q <= 64'h0;
        else       instret_q <= instret_d;
    end

    assign instret = instret_q;
`else
    assign instret = 64'h0;
`endif

endmodule

// File: tb/tb_writeback_pc.sv
// tb_writeback_pc: directed bench for writeback_pc with hand-computed values.
module tb_writeback_pc;

    logic        clk;
    logic        reset;
    logic [3:0]  icode, rA, rB;
    logic        cnd;
    logic [63:0] valC, valP, valE, valM;
    logic        instr_valid, imem_error, dmem_error;
    logic [63:0] valA, valB, pc, instret;
    logic [2:0]  stat;

    int checks = 0;
    int errors = 0;

    writeback_pc #(
        .RESET_PC(64'h100),
        .RSP_INIT(64'h200)
    ) dut (
        .clk(clk),
        .reset(reset),
        .icode(icode),
        .rA(rA),
        .rB(rB),
        .cnd(cnd),
        .valC(valC),
        .valP(valP),
        .valE(valE),
        .valM(valM),
        .instr_valid(instr_valid),
        .imem_error(imem_error),
        .dmem_error(dmem_error),
        .valA(valA),
        .valB(valB),
        .pc(pc),
        .stat(stat),
        .instret(instret)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] exp_ir(input int n);
`ifdef WB_INSTRET_EN
        return 64'(n);
`else
        return 64'(n - n);
`endif
    endfunction

    task automatic drive(input logic [3:0] ic, input logic [3:0] a, input logic [3:0] b,
                         input logic c, input logic [63:0] vc, input logic [63:0] vp,
                         input logic [63:0] ve, input logic [63:0] vm);
        icode = ic; rA = a; rB = b; cnd = c;
        valC = vc; valP = vp; valE = ve; valM = vm;
        instr_valid = 1'b1; imem_error = 1'b0; dmem_error = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Read register r through port A using rrmovq (srcA = rA), no clock.
    task automatic peek(input logic [3:0] r, input string tag, input logic [63:0] exp);
        drive(4'h2, r, 4'hF, 1'b0, 64'h0, 64'h0, 64'h0, 64'h0);
        #1;
        chk(tag, valA, exp);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        #1;
        reset = 1'b0;
    endtask

    initial begin
        drive(4'h1, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0, 64'h0, 64'h0);
        reset = 1'b1;
        step();
        step();
        // Reset state while reset is held.
        chk("rst_pc", pc, 64'h100);
        chk("rst_stat", {61'h0, stat}, 64'h1);
        chk("rst_instret", instret, 64'h0);
        drive(4'hA, 4'h4, 4'hF, 1'b0, 64'h0, 64'h0, 64'h0, 64'h0);
        #1;
        chk("rst_rsp_a", valA, 64'h200);
        chk("rst_rsp_b", valB, 64'h200);
        peek(4'hF, "read_none", 64'h0);
        reset = 1'b0;

        // irmovq 0x55 -> r2
        drive(4'h3, 4'hF, 4'h2, 1'b0, 64'h0, 64'h10A, 64'h55, 64'h0);
        step();
        chk("irmov_pc", pc, 64'h10A);
        peek(4'h2, "irmov_r2", 64'h55);

        // rrmovq r2->r3 with cnd=0: no write
        drive(4'h2, 4'h2, 4'h3, 1'b0, 64'h0, 64'h10C, 64'h55, 64'h0);
        step();
        chk("cmov_nc_pc", pc, 64'h10C);
        peek(4'h3, "cmov_nc_r3", 64'h0);

        // rrmovq r2->r3 with cnd=1: write
        drive(4'h2, 4'h2, 4'h3, 1'b1, 64'h0, 64'h10E, 64'h55, 64'h0);
        step();
        peek(4'h3, "cmov_c_r3", 64'h55);

        // popq %rsp: valM wins over valE
        drive(4'hB, 4'h4, 4'hF, 1'b0, 64'h0, 64'h110, 64'h208, 64'hDEAD);
        step();
        chk("popsp_pc", pc, 64'h110);
        drive(4'h9, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0, 64'h0, 64'h0);
        #1;
        chk("popsp_rsp", valA, 64'hDEAD);

        // ret: pc from valM, rsp from valE
        drive(4'h9, 4'hF, 4'hF, 1'b0, 64'h0, 64'h111, 64'hDEB5, 64'h40);
        step();
        chk("ret_pc", pc, 64'h40);
        peek(4'h4, "ret_rsp", 64'hDEB5);
        chk("instret_5", instret, exp_ir(5));

        // jXX taken / not taken
        drive(4'h7, 4'hF, 4'hF, 1'b1, 64'h300, 64'h49, 64'h0, 64'h0);
        step();
        chk("jxx_t_pc", pc, 64'h300);
        drive(4'h7, 4'hF, 4'hF, 1'b0, 64'h700, 64'h109, 64'h0, 64'h0);
        step();
        chk("jxx_nt_pc", pc, 64'h109);

        // call
        drive(4'h8, 4'hF, 4'hF, 1'b0, 64'h500, 64'h112, 64'hDEAD, 64'h0);
        step();
        chk("call_pc", pc, 64'h500);
        peek(4'h4, "call_rsp", 64'hDEAD);

        // mrmovq -> r6 from valM; opq reads it through srcA
        drive(4'h5, 4'h6, 4'h1, 1'b0, 64'h0, 64'h50A, 64'h999, 64'h1234);
        step();
        chk("mrmov_pc", pc, 64'h50A);
        drive(4'h6, 4'h6, 4'h2, 1'b0, 64'h0, 64'h0, 64'h0, 64'h0);
        #1;
        chk("opq_a", valA, 64'h1234);
        chk("opq_b", valB, 64'h55);
        chk("instret_9", instret, exp_ir(9));

        // dmem_error with instr_valid=0: ADR wins, no write
        drive(4'h3, 4'hF, 4'h7, 1'b0, 64'h0, 64'h600, 64'h77, 64'h0);
        dmem_error = 1'b1;
        instr_valid = 1'b0;
        step();
        chk("adr_stat", {61'h0, stat}, 64'h3);
        chk("adr_pc", pc, 64'h50A);
        peek(4'h7, "adr_r7", 64'h0);

        // Frozen: valid instructions ignored
        drive(4'h3, 4'hF, 4'h7, 1'b0, 64'h0, 64'h700, 64'h99, 64'h0);
        step();
        step();
        chk("frz_stat", {61'h0, stat}, 64'h3);
        chk("frz_pc", pc, 64'h50A);
        chk("frz_instret", instret, exp_ir(9));
        peek(4'h7, "frz_r7", 64'h0);

        // Asynchronous reset mid-instruction
        drive(4'h3, 4'hF, 4'h6, 1'b0, 64'h0, 64'h800, 64'hBAD, 64'h0);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_pc", pc, 64'h100);
        chk("arst_stat", {61'h0, stat}, 64'h1);
        chk("arst_instret", instret, 64'h0);
        peek(4'h6, "arst_r6", 64'h0);
        peek(4'h4, "arst_rsp", 64'h200);
        step();
        reset = 1'b0;

        // INS from !instr_valid beats halt
        drive(4'h0, 4'hF, 4'hF, 1'b0, 64'h0, 64'h101, 64'h0, 64'h0);
        instr_valid = 1'b0;
        step();
        chk("ins_stat", {61'h0, stat}, 64'h4);
        chk("ins_pc", pc, 64'h100);
        do_reset();

        // imem_error -> ADR
        drive(4'h1, 4'hF, 4'hF, 1'b0, 64'h0, 64'h101, 64'h0, 64'h0);
        imem_error = 1'b1;
        step();
        chk("imem_stat", {61'h0, stat}, 64'h3);
        do_reset();

        // Two commits then halt
        drive(4'h1, 4'hF, 4'hF, 1'b0, 64'h0, 64'h101, 64'h0, 64'h0);
        step();
        drive(4'h3, 4'hF, 4'h5, 1'b0, 64'h0, 64'h10B, 64'h33, 64'h0);
        step();
        drive(4'h0, 4'hF, 4'hF, 1'b0, 64'h0, 64'h10C, 64'h0, 64'h0);
        step();
        chk("hlt_stat", {61'h0, stat}, 64'h2);
        chk("hlt_pc", pc, 64'h10B);
        chk("hlt_instret", instret, exp_ir(2));
        drive(4'h3, 4'hF, 4'h5, 1'b0, 64'h0, 64'h200, 64'h44, 64'h0);
        step();
        chk("hlt_hold_pc", pc, 64'h10B);
        peek(4'h5, "hlt_r5", 64'h33);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
